// File: rtl/apu_sfx_if.sv
// apu_sfx_if: the trigger-to-audio link of the APU.
//   Trigger side (driven by master): frame_end, eat_sound, die_sound, hit_sound
//   Player side (driven by slave):   audio_out, busy, sfx_id[1:0], step_idx[1:0]
interface apu_sfx_if;
  logic       frame_end;
  logic       eat_sound;
  logic       die_sound;
  logic       hit_sound;
  logic       audio_out;
  logic       busy;
  logic [1:0] sfx_id;
  logic [1:0] step_idx;

  modport master (
    output frame_end, eat_sound, die_sound, hit_sound,
    input  audio_out, busy, sfx_id, step_idx
  );

  modport slave (
    input  frame_end, eat_sound, die_sound, hit_sound,
    output audio_out, busy, sfx_id, step_idx
  );
endinterface

// File: rtl/apu_sfx_player.sv
// apu_sfx_player: plays a fixed four-step square-wave effect for each of the
// eat / die / hit trigger pulses, paced by the video frame_end strobe.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : apu_sfx_if.slave
//            in  frame_end, eat_sound, die_sound, hit_sound (one-cycle pulses)
//            out audio_out (1-bit square wave), busy, sfx_id (00 none,
//                01 eat, 10 die, 11 hit), step_idx (note step 0-3)
// Parameters: STEP_FRAMES frame_end strobes per note step (>=1),
//             PERIOD_W width of the tone half-period counter.
module apu_sfx_player #(
  parameter int STEP_FRAMES = 4,
  parameter int PERIOD_W    = 16
) (
  input  logic      clk,
  input  logic      reset,
  apu_sfx_if.slave  bus
);

  localparam int FC_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(STEP_FRAMES - 1);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  busy_q;
  logic [1:0]            sfx_q, sfx_d;
  logic [1:0]            step_q, step_d;
  logic [FC_W-1:0]       frame_q, frame_d;
  logic [PERIOD_W-1:0]   tone_q, tone_d;
  logic                  audio_q, audio_d;
  logic [1:0]            trig_id;
  logic [PERIOD_W-1:0]   half;

  // Half-period (clk cycles) of each note; 0 is a rest.
  function automatic logic [PERIOD_W-1:0] half_period(input logic [1:0] id,
                                                      input logic [1:0] step);
    logic [PERIOD_W-1:0] h;
    h = '0;
    case ({id, step})
      4'b01_00: h = PERIOD_W'(24000);
      4'b01_01: h = PERIOD_W'(18000);
      4'b01_10: h = PERIOD_W'(14000);
      4'b01_11: h = PERIOD_W'(12000);
      4'b10_00: h = PERIOD_W'(20000);
      4'b10_01: h = PERIOD_W'(26000);
      4'b10_10: h = PERIOD_W'(34000);
      4'b10_11: h = PERIOD_W'(45000);
      4'b11_00: h = PERIOD_W'(30000);
      4'b11_10: h = PERIOD_W'(30000);
      default:  h = '0;
    endcase
    return h;
  endfunction

  // The id encoding doubles as the priority: hit(3) > die(2) > eat(1).
  assign trig_id = bus.hit_sound ? 2'd3 :
                   bus.die_sound ? 2'd2 :
                   bus.eat_sound ? 2'd1 : 2'd0;

  assign half = half_period(sfx_q, step_q);

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    sfx_d   = sfx_q;
    step_d  = step_q;
    frame_d = frame_q;
    tone_d  = tone_q;
    audio_d = audio_q;

    // sfx_q is 00 in IDLE, so one compare covers both the idle accept and
    // equal-or-higher priority preemption. An accept beats a same-cycle
    // frame_end, which is simply not counted.
    if (trig_id != 2'd0 && trig_id >= sfx_q) begin
      state_d = PLAY;
      sfx_d   = trig_id;
      step_d  = 2'd0;
      frame_d = '0;
      tone_d  = '0;
      audio_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sfx_d   = 2'd0;
          step_d  = 2'd0;
          frame_d = '0;
          tone_d  = '0;
          audio_d = 1'b0;
        end
        PLAY: begin
          if (half == '0) begin
            tone_d  = '0;
            audio_d = 1'b0;
          end else if (tone_q == half - 1'b1) begin
            tone_d  = '0;
            audio_d = ~audio_q;
          end else begin
            tone_d = tone_q + 1'b1;
          end

          // A step boundary restarts the tone from a low level.
          if (bus.frame_end) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              tone_d  = '0;
              audio_d = 1'b0;
              if (step_q == 2'd3) begin
                state_d = IDLE;
                sfx_d   = 2'd0;
                step_d  = 2'd0;
              end else begin
                step_d = step_q + 1'b1;
              end
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      sfx_q   <= 2'd0;
      step_q  <= 2'd0;
      frame_q <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == PLAY);
      sfx_q   <= sfx_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      tone_q  <= tone_d;
      audio_q <= audio_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.busy      = busy_q;
  assign bus.sfx_id    = sfx_q;
  assign bus.step_idx  = step_q;

endmodule

// File: tb/tb_apu_sfx_player.sv
// tb_apu_sfx_player: directed stimulus for apu_sfx_player. The stimulus
// process queues the hand-computed {audio_out, busy, sfx_id, step_idx} value
// expected after a given clock edge; a monitor on the falling edge pops and
// compares each entry when its edge has been reached.
module tb_apu_sfx_player;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [5:0] val;   // {audio_out, busy, sfx_id, step_idx}
  } exp_t;

  exp_t sb[$];

  apu_sfx_if bus ();

  apu_sfx_player #(.STEP_FRAMES(4), .PERIOD_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [5:0] act,
                       input logic [5:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got {audio,busy,id,step}=%b required %b",
               name, cyc, act, req);
    end
  endtask

  // Monitor: compare every queued expectation whose edge has come.
  always @(negedge clk) begin
    logic [5:0] act;
    act = {bus.audio_out, bus.busy, bus.sfx_id, bus.step_idx};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: slot at cycle %0d passed unchecked (now %0d)",
                 sb[0].name, sb[0].cyc, cyc);
      end else begin
        check(sb[0].name, act, sb[0].val);
      end
      void'(sb.pop_front());
    end
  end

  task automatic expect_at(input int c, input string name, input logic a,
                           input logic b, input logic [1:0] id,
                           input logic [1:0] st);
    sb.push_back('{c, name, {a, b, id, st}});
  endtask

  // Advance n rising edges and step just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // NOTE: inputs are driven with blocking assignments just after the edge,
  // so the DUT samples them cleanly on the next rising edge.
  task automatic pulse(input logic e, input logic d, input logic h,
                       input logic f);
    bus.eat_sound = e;
    bus.die_sound = d;
    bus.hit_sound = h;
    bus.frame_end = f;
    tick(1);
    bus.eat_sound = 1'b0;
    bus.die_sound = 1'b0;
    bus.hit_sound = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  // Strobes k0..k1 of an effect (counted from acceptance), STEP_FRAMES = 4.
  // Tones are far longer than these windows, so audio stays low.
  task automatic strobes(input int k0, input int k1, input logic [1:0] id);
    for (int k = k0; k <= k1; k++) begin
      tick(1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_at(cyc, $sformatf("strobe%0d_id%0d", k, id), 1'b0, (k < 16),
                (k < 16) ? id : 2'd0, (k < 16) ? 2'(k / 4) : 2'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    bus.eat_sound = 1'b0;
    bus.die_sound = 1'b0;
    bus.hit_sound = 1'b0;
    bus.frame_end = 1'b0;

    // Reset with a trigger present: the trigger is ignored.
    reset = 1'b1;
    bus.eat_sound = 1'b1;
    tick(3);
    expect_at(cyc, "reset_hold", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    bus.eat_sound = 1'b0;
    tick(1);
    expect_at(cyc, "post_reset_idle", 1'b0, 1'b0, 2'd0, 2'd0);

    // Eat from IDLE: first note H = 24000.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    a = cyc;
    expect_at(a,         "eat_accept",   1'b0, 1'b1, 2'd1, 2'd0);
    expect_at(a + 23999, "eat_pre_rise", 1'b0, 1'b1, 2'd1, 2'd0);
    expect_at(a + 24000, "eat_rise",     1'b1, 1'b1, 2'd1, 2'd0);
    expect_at(a + 47999, "eat_pre_fall", 1'b1, 1'b1, 2'd1, 2'd0);
    expect_at(a + 48000, "eat_fall",     1'b0, 1'b1, 2'd1, 2'd0);
    tick(48000);
    strobes(1, 16, 2'd1);

    // frame_end in IDLE changes nothing.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(cyc, "idle_frame_end", 1'b0, 1'b0, 2'd0, 2'd0);

    // All three at once: hit wins. Step 1 of hit is a rest.
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    expect_at(cyc, "all_three_hit", 1'b0, 1'b1, 2'd3, 2'd0);
    strobes(1, 4, 2'd3);
    expect_at(cyc + 100, "hit_rest_quiet", 1'b0, 1'b1, 2'd3, 2'd1);
    tick(100);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_at(cyc, "eat_ignored", 1'b0, 1'b1, 2'd3, 2'd1);
    strobes(5, 16, 2'd3);

    // die + eat together: die wins; hit preempts it at step 2.
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    expect_at(cyc, "die_over_eat", 1'b0, 1'b1, 2'd2, 2'd0);
    strobes(1, 8, 2'd2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_at(cyc, "hit_preempt", 1'b0, 1'b1, 2'd3, 2'd0);

    // Trigger with frame_end on the step boundary: accept wins, no advance.
    strobes(1, 3, 2'd3);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    expect_at(cyc, "hit_vs_frame_end", 1'b0, 1'b1, 2'd3, 2'd0);
    strobes(1, 4, 2'd3);

    // Back-to-back hit pulses each restart the effect.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_at(cyc, "b2b_hit_1", 1'b0, 1'b1, 2'd3, 2'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_at(cyc, "b2b_hit_2", 1'b0, 1'b1, 2'd3, 2'd0);
    strobes(1, 16, 2'd3);

    // Eat step 1 (H = 18000) until audio is high, then reset mid-effect.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_at(cyc, "eat2_accept", 1'b0, 1'b1, 2'd1, 2'd0);
    strobes(1, 4, 2'd1);
    a = cyc;
    expect_at(a + 17999, "eat_s1_pre_rise", 1'b0, 1'b1, 2'd1, 2'd1);
    expect_at(a + 18000, "eat_s1_rise",     1'b1, 1'b1, 2'd1, 2'd1);
    tick(18000);
    reset = 1'b1;
    tick(1);
    expect_at(cyc, "reset_mid_effect", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    tick(1);
    expect_at(cyc, "after_mid_reset", 1'b0, 1'b0, 2'd0, 2'd0);

    tick(3);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
